// File: rtl/ram_seq_ctrl_pkg.sv
// ram_seq_pkg: shared state encoding and default geometry for the RAM sequencer.
package ram_seq_pkg;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;
    localparam int RAM_DEPTH  = 2 ** ADDR_W_DEF;
    typedef enum logic [2:0] {IDLE, FILL, SCAN_RD, SCAN_CAP, SCAN_WAIT} state_t;
endpackage

// File: rtl/ram_seq_ctrl_tick_counter.sv
// tick_counter: counts 0..TICK_DIV-3 while enabled, flags the terminal count.
module tick_counter #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TICK_DIV);
    logic [CW-1:0] cnt;
    assign tc = cnt == CW'(TICK_DIV - 3);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tc ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: manual pass-through, fill and slow-scan sequencer in front of a single-port RAM.
// Define RAM_SCAN_LOOP_EN to make the scan wrap continuously until start_scan is seen in SCAN_WAIT.
module ram_seq_ctrl
    import ram_seq_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TICK_DIV = 50000000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start_fill,
    input  logic              start_scan,
    input  logic [DATA_W-1:0] fill_seed,
    input  logic [ADDR_W-1:0] man_addr,
    input  logic [DATA_W-1:0] man_data,
    input  logic              man_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [DATA_W-1:0] cur_data,
    output logic              busy,
    output logic              done
);
    state_t state, state_n;
    logic [ADDR_W-1:0] index;
    logic tc, last, scan_end, idle;

    tick_counter #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk(CLOCK_50),
        .rst(reset),
        .clr(state == SCAN_CAP),
        .en (state == SCAN_WAIT),
        .tc (tc)
    );

    assign last = &index;
`ifdef RAM_SCAN_LOOP_EN
    logic stop_req;
    assign scan_end = stop_req | start_scan;
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) stop_req <= 1'b0;
        else stop_req <= (state == SCAN_WAIT) & (stop_req | start_scan);
    end
`else
    assign scan_end = last;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = start_fill ? FILL : start_scan ? SCAN_RD : IDLE;
            FILL:      state_n = last ? IDLE : FILL;
            SCAN_RD:   state_n = SCAN_CAP;
            SCAN_CAP:  state_n = SCAN_WAIT;
            SCAN_WAIT: state_n = tc ? (scan_end ? IDLE : SCAN_RD) : SCAN_WAIT;
            default:   state_n = IDLE;
        endcase
    end

    // Reset gates the write strobe because the idle mux would otherwise pass man_wren through.
    always_comb begin
        idle     = state == IDLE;
        busy     = !idle;
        ram_addr = idle ? man_addr : index;
        ram_data = idle ? man_data : fill_seed + DATA_W'(index);
        ram_wren = !reset && (idle ? man_wren : state == FILL);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            index    <= '0;
            cur_addr <= '0;
            cur_data <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == FILL && last) || (state == SCAN_WAIT && tc && scan_end);
            if (idle) index <= '0;
            else if (state == FILL || (state == SCAN_WAIT && tc)) index <= index + 1'b1;
            if (state == SCAN_CAP) begin
                cur_addr <= index;
                cur_data <= ram_q;
            end
        end
    end
endmodule

// File: tb/tb_ram_seq_ctrl.sv
// tb_ram_seq_ctrl: directed bench with a behavioural RAM and an expected-value queue.
module tb_ram_seq_ctrl;
    localparam int AW = 5, DW = 8, TD = 4;
    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} exp_t;

    logic CLOCK_50 = 0, reset = 1, start_fill = 0, start_scan = 0, man_wren = 1;
    logic [DW-1:0] fill_seed = 0, man_data = 0, ram_q, ram_data, cur_data;
    logic [AW-1:0] man_addr = 0, ram_addr, cur_addr;
    logic ram_wren, busy, done;
    logic [DW-1:0] mem [32];
    exp_t q[$];
    int checks = 0, errors = 0;

    ram_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TICK_DIV(TD)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start_fill(start_fill), .start_scan(start_scan),
        .fill_seed(fill_seed), .man_addr(man_addr), .man_data(man_data), .man_wren(man_wren),
        .ram_q(ram_q), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
        .cur_addr(cur_addr), .cur_data(cur_data), .busy(busy), .done(done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_fill(input logic [DW-1:0] seed, input logic both);
        exp_t e;
        @(negedge CLOCK_50);
        fill_seed = seed; start_fill = 1; start_scan = both;
        for (int i = 0; i < 32; i++) begin
            e.a = i[AW-1:0]; e.d = seed + i[DW-1:0];
            q.push_back(e);
        end
        @(negedge CLOCK_50);
        start_fill = 0; start_scan = 0;
        for (int i = 0; i < 32; i++) begin
            e = q.pop_front();
            chk("fill_write", 32'({busy, done, ram_wren, ram_addr, ram_data}), 32'({3'b101, e}));
            start_scan = both && i == 10;
            @(negedge CLOCK_50);
        end
        chk("fill_done", 32'({done, busy}), 32'b10);
        @(negedge CLOCK_50);
        chk("fill_done_once", 32'({done, busy}), 32'b00);
    endtask

    task automatic run_scan(input int n, input logic [DW-1:0] seed);
        exp_t e, l;
        @(negedge CLOCK_50);
        start_scan = 1;
        for (int k = 0; k < n; k++) begin
            e.a = k[AW-1:0]; e.d = seed + e.a;
            q.push_back(e);
        end
        @(negedge CLOCK_50);
        start_scan = 0;
        repeat (2) @(negedge CLOCK_50);
        for (int k = 0; k < n; k++) begin
            e = q.pop_front();
            chk("scan_capture", 32'({done, busy, cur_addr, cur_data}), 32'({2'b01, e}));
            if (k < n - 1) repeat (4) @(negedge CLOCK_50);
        end
        l = e;
        start_scan = 1;
        @(negedge CLOCK_50);
        start_scan = 0;
        chk("scan_last_wait", 32'({done, busy}), 32'b01);
        @(negedge CLOCK_50);
        chk("scan_done", 32'({done, busy, cur_addr, cur_data}), 32'({2'b10, l}));
        @(negedge CLOCK_50);
        chk("scan_done_once", 32'({done, busy, cur_addr, cur_data}), 32'({2'b00, l}));
    endtask

    initial begin
        #2;
        chk("rst_wren", 32'(ram_wren), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cur", 32'({cur_addr, cur_data}), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge CLOCK_50);
        reset = 0; man_wren = 0; man_addr = 5'h0A; man_data = 8'h55;
        #1 chk("man_addr", 32'({ram_wren, ram_addr, ram_data}), 32'({1'b0, 5'h0A, 8'h55}));
        man_wren = 1; man_addr = 5'h03;
        #1 chk("man_wren", 32'({ram_wren, ram_addr}), 32'({1'b1, 5'h03}));
        man_wren = 0;

        run_fill(8'hF0, 1'b0);
        run_fill(8'h10, 1'b1);
        repeat (3) begin
            @(negedge CLOCK_50);
            chk("no_scan_after_fill", 32'({busy, done, cur_addr}), 0);
        end

        run_scan(32, 8'h10);
        repeat (3) begin
            @(negedge CLOCK_50);
            chk("idle_hold", 32'({busy, cur_addr, cur_data}), 32'({1'b0, 5'd31, 8'h2F}));
        end

        @(negedge CLOCK_50);
        start_scan = 1;
        @(negedge CLOCK_50);
        start_scan = 0;
        repeat (2 + 4 * 7) @(negedge CLOCK_50);
        chk("scan_idx7", 32'({busy, cur_addr, cur_data}), 32'({1'b1, 5'd7, 8'h17}));
        man_wren = 1;
        #2 reset = 1;
        #1 chk("abort_state", 32'({busy, done, ram_wren, cur_addr, cur_data}), 0);
        @(negedge CLOCK_50);
        reset = 0; man_wren = 0;
        repeat (6) begin
            @(negedge CLOCK_50);
            chk("abort_no_done", 32'({busy, done, cur_addr}), 0);
        end

`ifdef RAM_SCAN_LOOP_EN
        run_scan(34, 8'h10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_seq_ctrl.md
Name: ram_seq_ctrl

Overview:
Sequencer that sits directly upstream of the 32x8 single-port RAM (ramlpm) and drives its address/data/wren inputs.
- Idle: passes the manual switch-level address/data/write-enable straight through to the RAM.
- Fill: on command, writes an incrementing pattern into every word.
- Scan: on command, steps through all words at a slow tick rate and captures each read byte for the HEX display decoders downstream.

Parameters:
- ADDR_W, 5, RAM address width (depth = 2**ADDR_W = 32).
- DATA_W, 8, RAM word width.
- TICK_DIV, 50000000, CLOCK_50 cycles per scan step (1 s at 50 MHz). Minimum 4. Benches use 4.

Ports:
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_fill  in  1  level-sampled request to start a fill pass.
- start_scan  in  1  level-sampled request to start a scan pass.
- fill_seed  in  DATA_W  base value for the fill pattern.
- man_addr  in  ADDR_W  manual address (idle pass-through).
- man_data  in  DATA_W  manual write data (idle pass-through).
- man_wren  in  1  manual write enable (idle pass-through).
- ram_q  in  DATA_W  RAM read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_data  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable.
- cur_addr  out  ADDR_W  address of the last captured word.
- cur_data  out  DATA_W  last captured read byte.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of a fill or scan pass.

Behaviour:
Reset (async, active-high):
- state=IDLE; index, tick counter, cur_addr, cur_data all 0; busy=0; done=0.
- While reset is high, ram_wren=0 regardless of man_wren.
- Reset asserted mid-pass aborts the pass immediately. No done pulse.

RAM timing: the RAM registers its address. ram_q for address A is sampled on the 2nd rising edge after ram_addr=A is presented.

IDLE:
- ram_addr=man_addr, ram_data=man_data, ram_wren=man_wren (combinational).
- start_fill=1 -> FILL with index=0.
- else start_scan=1 -> SCAN_RD with index=0. Fill wins if both are high.
- A held start re-triggers after the pass ends (level-sensitive).

FILL:
- ram_wren=1, ram_addr=index, ram_data=(fill_seed+index) mod 2**DATA_W.
- fill_seed is sampled live every cycle.
- index increments each cycle, so exactly 32 consecutive write cycles.
- After index=31: done=1 for one cycle, -> IDLE, ram_wren returns to manual.

SCAN_RD:
- ram_wren=0, ram_addr=index. Next cycle -> SCAN_CAP.

SCAN_CAP:
- ram_addr held.
- On the exit edge: cur_data<=ram_q, cur_addr<=index, tick counter<=0. -> SCAN_WAIT.

SCAN_WAIT:
- ram_wren=0. Tick counter counts up.
- When the count reaches TICK_DIV-3: if index=31, pulse done and -> IDLE; else index+1 and -> SCAN_RD.
- Each step therefore takes exactly TICK_DIV cycles.

During FILL and all SCAN states:
- start_* and man_* inputs are ignored.
- busy=1.
- cur_addr/cur_data change only on the SCAN_CAP exit edge and hold their value in IDLE.

Index wrap: modulo 2**ADDR_W. Never exceeds 31.

Optional Feature:
RAM_SCAN_LOOP_EN
- Defined: after index=31 the scan wraps to index 0 and continues, with no done pulse. It exits to IDLE (done pulse) at the end of the current step if start_scan is sampled high during SCAN_WAIT. start_fill is still ignored while scanning.
- Undefined: single pass, as above.

Decomposition:
- Package ram_seq_pkg: state enum (IDLE, FILL, SCAN_RD, SCAN_CAP, SCAN_WAIT), ADDR_W/DATA_W defaults, RAM_DEPTH constant.
- One natural sub-module, tick_counter: a TICK_DIV-3 terminal counter with clear input and terminal-count output.
- The output mux stays in ram_seq_ctrl.

Test Plan:
1. Reset with man_wren=1 -> ram_wren=0, busy=0, cur_data=0. After release, ram_addr follows man_addr=5'h0A with zero latency.
2. fill_seed=8'hF0, start_fill pulse -> 32 writes, addr 0..31, data F0..FF then 00..0F; done pulses one cycle after the addr-31 write; busy low in that same cycle.
3. After fill (seed 8'h10), start_scan, TICK_DIV=4 -> cur_addr/cur_data update every 4 cycles with (0,10),(1,11)...(31,2F); single done pulse.
4. start_fill and start_scan high together in IDLE -> FILL taken. Later start_scan pulses during fill are ignored; no scan occurs.
5. Reset asserted during scan at index 7 -> immediate IDLE, no done pulse, cur_addr=0.
6. RAM_SCAN_LOOP_EN defined -> after cur_addr=31 the next capture is cur_addr=0. start_scan during SCAN_WAIT ends the scan with one done pulse.
